// File: rtl/rom4001_bus.sv
// rom4001_bus
//   4001-style program ROM plus 4-bit I/O port on the CPU's multiplexed bus.
//   Follows the 8-phase instruction cycle from SYNC_N and latches the fetch
//   address during A1..A3. When the chip number matches, it drives the
//   addressed opcode byte during M1 and M2. It also handles SRC, WRR and RDR
//   for its own ports.
//
//   Handshake: this block has no valid/ready pairs. It is a slave on a
//   phase-locked bus. Every input is sampled at the CLK edge that ends the
//   current phase. DATA_O/DATA_OE are registered and hold for exactly the
//   phase they belong to.
//
// Ports
//   CLK        system clock, one bus phase per cycle
//   RES        synchronous active-high reset
//   SYNC_N     low in X3, the phase before A1 (also resyncs mid-cycle)
//   DATA_I     resolved bus (CPU drive ORed with every peripheral drive)
//   CM_ROM_N   CPU ROM command line, active-low
//   DATA_O     nibble driven onto the bus, 0 when DATA_OE is low
//   DATA_OE    bus drive enable
//   IO_I       input port, read by RDR
//   IO_O       output port, written by WRR
//   PROG_WE    ROM array write strobe (any edge, any phase)
//   PROG_ADDR  ROM array write address
//   PROG_DATA  ROM array write data
//   PHASE      debug view of the phase tracker:
//              0=IDLE 1=A1 2=A2 3=A3 4=M1 5=M2 6=X1 7=X2 8=X3
module rom4001_bus #(
   parameter logic [3:0] CHIP_ID = 4'h0
) (
   input  logic       CLK,
   input  logic       RES,
   input  logic       SYNC_N,
   input  logic [3:0] DATA_I,
   input  logic       CM_ROM_N,
   output logic [3:0] DATA_O,
   output logic       DATA_OE,
   input  logic [3:0] IO_I,
   output logic [3:0] IO_O,
   input  logic       PROG_WE,
   input  logic [7:0] PROG_ADDR,
   input  logic [7:0] PROG_DATA,
   output logic [3:0] PHASE
);

   typedef enum logic [3:0] {
      P_IDLE = 4'd0,
      P_A1   = 4'd1,
      P_A2   = 4'd2,
      P_A3   = 4'd3,
      P_M1   = 4'd4,
      P_M2   = 4'd5,
      P_X1   = 4'd6,
      P_X2   = 4'd7,
      P_X3   = 4'd8
   } phase_t;

   phase_t     state, state_nxt;
   logic [7:0] rom [256];
   logic [7:0] addr;
   logic [3:0] obuf;     // low opcode nibble kept for M2; the high nibble goes out directly in M1
   logic [3:0] opr;
   logic       hit;
   logic       io_sel;
   logic       wrr;
   logic       rdr;
   logic       a3_hit;
   logic       io_cmd;

   assign PHASE  = state;
   assign a3_hit = (DATA_I == CHIP_ID) && !CM_ROM_N;
   assign io_cmd = (opr == 4'hE) && !CM_ROM_N && io_sel;

   // A low SYNC_N always restarts the cycle at A1, including mid-cycle.
   always_comb begin
      state_nxt = state;
      if (!SYNC_N) begin
         state_nxt = P_A1;
      end else begin
         case (state)
            P_IDLE:  state_nxt = P_IDLE;
            P_A1:    state_nxt = P_A2;
            P_A2:    state_nxt = P_A3;
            P_A3:    state_nxt = P_M1;
            P_M1:    state_nxt = P_M2;
            P_M2:    state_nxt = P_X1;
            P_X1:    state_nxt = P_X2;
            P_X2:    state_nxt = P_X3;
            P_X3:    state_nxt = P_A1;
            default: state_nxt = P_IDLE;
         endcase
      end
   end

   // The array is not reset. The fetch reads it with a non-blocking read in
   // the block below, so a write on the same edge returns the old byte.
   always_ff @(posedge CLK) begin
      if (PROG_WE) rom[PROG_ADDR] <= PROG_DATA;
   end

   // Drive enables are set one edge ahead of the phase they cover. Each one
   // is gated by SYNC_N so that an abort never drives in the new A1.
   always_ff @(posedge CLK) begin
      if (RES) begin
         state   <= P_IDLE;
         addr    <= 8'h00;
         obuf    <= 4'h0;
         opr     <= 4'h0;
         hit     <= 1'b0;
         io_sel  <= 1'b0;
         wrr     <= 1'b0;
         rdr     <= 1'b0;
         IO_O    <= 4'h0;
         DATA_O  <= 4'h0;
         DATA_OE <= 1'b0;
      end else begin
         state   <= state_nxt;
         DATA_O  <= 4'h0;
         DATA_OE <= 1'b0;
         case (state)
            P_A1: addr[3:0] <= DATA_I;
            P_A2: addr[7:4] <= DATA_I;
            P_A3: begin
               hit <= a3_hit;
               if (a3_hit && SYNC_N) begin
                  obuf    <= rom[addr][3:0];
                  DATA_O  <= rom[addr][7:4];
                  DATA_OE <= 1'b1;
               end
            end
            P_M1: begin
               opr <= DATA_I;  // resolved bus, so opcodes from other chips are seen too
               if (hit && SYNC_N) begin
                  DATA_O  <= obuf;
                  DATA_OE <= 1'b1;
               end
            end
            P_M2: begin
               if (io_cmd && SYNC_N) begin
                  wrr <= (DATA_I == 4'h2);
                  rdr <= (DATA_I == 4'hA);
               end
            end
            P_X1: begin
               // DATA_O doubles as the RDR input buffer: it captures IO_I here
               if (rdr && SYNC_N) begin
                  DATA_O  <= IO_I;
                  DATA_OE <= 1'b1;
               end
            end
            P_X2: begin
               if (!CM_ROM_N) io_sel <= (DATA_I == CHIP_ID);
               if (wrr && SYNC_N) IO_O <= DATA_I;
            end
            P_X3: begin
               wrr <= 1'b0;
               rdr <= 1'b0;
            end
            default: ;
         endcase
         if (!SYNC_N) begin
            wrr <= 1'b0;
            rdr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rom4001_bus.sv
// tb_rom4001_bus
//   Bench for rom4001_bus. It drives whole bus cycles (A1..X3) phase by phase.
//   The bus is resolved as the CPU drive ORed with the DUT's drive. At mid-phase
//   it records DATA_OE/DATA_O/IO_O/PHASE for each phase and checks them against
//   expected words queued by two sources: a table of hand-computed cycles, and
//   a cycle-level model for randomized traffic.
module tb_rom4001_bus;

   localparam logic [3:0] CHIP = 4'h0;

   typedef struct {
      logic [7:0] a;
      logic [3:0] a3;
      logic       cm_a3;
      logic [3:0] m1;
      logic [3:0] m2;
      logic       cm_m2;
      logic       cm_x2;
      logic [3:0] x2;
      logic [3:0] io_in;
      int         abort_k;   // phase index with SYNC_N low; 7 = normal X3
      logic       e_m1oe;
      logic [3:0] e_m1;
      logic       e_m2oe;
      logic [3:0] e_m2;
      logic       e_x2oe;
      logic [3:0] e_x2;
      logic [3:0] e_io0;     // IO_O expected in A1..X2
      logic [3:0] e_io7;     // IO_O expected in X3
   } vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       res;
   logic       sync_n;
   logic       cm_rom_n;
   logic [3:0] cpu_d;
   logic [3:0] data_i;
   logic [3:0] data_o;
   logic       data_oe;
   logic [3:0] io_i;
   logic [3:0] io_o;
   logic       prog_we;
   logic [7:0] prog_addr;
   logic [7:0] prog_data;
   logic [3:0] phase;

   always #5 clk = ~clk;

   assign data_i = cpu_d | (data_oe ? data_o : 4'h0);

   rom4001_bus #(.CHIP_ID(CHIP)) dut (
      .CLK       (clk),
      .RES       (res),
      .SYNC_N    (sync_n),
      .DATA_I    (data_i),
      .CM_ROM_N  (cm_rom_n),
      .DATA_O    (data_o),
      .DATA_OE   (data_oe),
      .IO_I      (io_i),
      .IO_O      (io_o),
      .PROG_WE   (prog_we),
      .PROG_ADDR (prog_addr),
      .PROG_DATA (prog_data),
      .PHASE     (phase)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bench state ----------------
   int         n_vec = 0;
   int         n_bad = 0;
   logic [8:0] exp_q[$];        // {oe, data_o, io_o} per observed phase
   logic       cap_oe [8];
   logic [3:0] cap_o  [8];
   logic [3:0] cap_io [8];
   logic [3:0] cap_ph [8];
   int         cap_n;
   logic [7:0] rom_m [256];     // mirror of every byte written into the DUT array
   logic       io_sel_m;
   logic [3:0] io_o_m;
   int         pw_k  = -1;      // phase with PROG_WE high, -1 none
   logic [7:0] pw_addr;
   logic [7:0] pw_data;
   int         res_k = -1;      // phase with RES high, -1 none
   vec_t       tbl [20];

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic [7:0] a, input logic [7:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      rom_m[a]  = d;
      step();
      prog_we   = 1'b0;
   endtask

   function automatic int last_of(input vec_t c);
      int l;
      l = c.abort_k;
      if (res_k >= 0 && res_k < l) l = res_k;
      return l;
   endfunction

   task automatic run_cycle(input vec_t c);
      int last;
      last = last_of(c);
      for (int k = 0; k <= last; k++) begin
         case (k)
            0:       cpu_d = c.a[3:0];
            1:       cpu_d = c.a[7:4];
            2:       cpu_d = c.a3;
            3:       cpu_d = c.m1;
            4:       cpu_d = c.m2;
            6:       cpu_d = c.x2;
            default: cpu_d = 4'h0;
         endcase
         cm_rom_n  = (k == 2) ? c.cm_a3 : (k == 4) ? c.cm_m2 : (k == 6) ? c.cm_x2 : 1'b1;
         sync_n    = (k == c.abort_k && k != res_k) ? 1'b0 : 1'b1;
         res       = (k == res_k);
         prog_we   = (k == pw_k);
         prog_addr = pw_addr;
         prog_data = pw_data;
         io_i      = c.io_in;
         if (k == pw_k) rom_m[pw_addr] = pw_data;
         #4;
         cap_oe[k] = data_oe;
         cap_o[k]  = data_o;
         cap_io[k] = io_o;
         cap_ph[k] = phase;
         step();
      end
      res      = 1'b0;
      prog_we  = 1'b0;
      sync_n   = 1'b1;
      cpu_d    = 4'h0;
      cm_rom_n = 1'b1;
      cap_n    = last;
   endtask

   // ---------------- expectation sources ----------------
   task automatic exp_from_vec(input vec_t c);
      logic       oe;
      logic [3:0] d;
      for (int k = 0; k <= last_of(c); k++) begin
         oe = 1'b0;
         d  = 4'h0;
         if (k == 3) begin oe = c.e_m1oe; d = c.e_m1; end
         if (k == 4) begin oe = c.e_m2oe; d = c.e_m2; end
         if (k == 6) begin oe = c.e_x2oe; d = c.e_x2; end
         exp_q.push_back({oe, d, (k == 7) ? c.e_io7 : c.e_io0});
      end
   endtask

   // Cycle-level reference: what a 4001 on this bus should drive in each phase
   // and how its port state moves, given the complete inputs for one cycle.
   task automatic model_cycle(input vec_t c);
      int         last;
      logic       hit, cmd, rdr_drv;
      logic [7:0] rd;
      logic [3:0] bm1, bm2, bx2;
      logic       oe [8];
      logic [3:0] d  [8];
      logic [3:0] io [8];
      last = last_of(c);
      hit  = (c.a3 == CHIP) && !c.cm_a3;
      rd   = rom_m[c.a];
      if (pw_k >= 0 && pw_k < 2 && pw_k <= last && pw_addr == c.a) rd = pw_data;
      bm1 = c.m1 | (hit ? rd[7:4] : 4'h0);
      bm2 = c.m2 | (hit ? rd[3:0] : 4'h0);
      for (int k = 0; k < 8; k++) begin
         oe[k] = 1'b0;
         d[k]  = 4'h0;
         io[k] = io_o_m;
      end
      if (hit && last >= 3) begin oe[3] = 1'b1; d[3] = rd[7:4]; end
      if (hit && last >= 4) begin oe[4] = 1'b1; d[4] = rd[3:0]; end
      cmd     = (last >= 5) && (bm1 == 4'hE) && !c.cm_m2 && io_sel_m;
      rdr_drv = cmd && (bm2 == 4'hA) && (last >= 6);
      if (rdr_drv) begin oe[6] = 1'b1; d[6] = c.io_in; end
      bx2 = c.x2 | (rdr_drv ? c.io_in : 4'h0);
      if (last == 7) begin
         if (cmd && bm2 == 4'h2) begin
            io_o_m = bx2;
            io[7]  = bx2;
         end
      end
      if (last >= 7 && !c.cm_x2) io_sel_m = (bx2 == CHIP);
      for (int k = 0; k <= last; k++) exp_q.push_back({oe[k], d[k], io[k]});
   endtask

   // ---------------- scoreboard ----------------
   task automatic cmp_cycle(input string tag, input int idx);
      logic [8:0] e;
      for (int k = 0; k <= cap_n; k++) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s #%0d phase %0d: no expected entry queued", tag, idx, k);
         end else begin
            e = exp_q.pop_front();
            if ({cap_oe[k], cap_o[k], cap_io[k]} !== e || cap_ph[k] !== 4'(k + 1)) begin
               n_bad++;
               $display("FAIL %s #%0d phase %0d: got oe=%b do=%h io=%h ph=%0d, want oe=%b do=%h io=%h ph=%0d",
                        tag, idx, k, cap_oe[k], cap_o[k], cap_io[k], cap_ph[k],
                        e[8], e[7:4], e[3:0], k + 1);
            end
         end
      end
   endtask

   // One phase while the tracker should sit in IDLE.
   task automatic chk_idle(input string tag, input logic sn, input logic [3:0] exp_io);
      sync_n = sn;
      cpu_d  = 4'h0;
      #4;
      n_vec++;
      if (data_oe !== 1'b0 || data_o !== 4'h0 || io_o !== exp_io || phase !== 4'd0) begin
         n_bad++;
         $display("FAIL %s: got oe=%b do=%h io=%h ph=%0d, want oe=0 do=0 io=%h ph=0",
                  tag, data_oe, data_o, io_o, phase, exp_io);
      end
      step();
      sync_n = 1'b1;
   endtask

   task automatic apply_vec(input vec_t c, input string tag, input int idx);
      exp_from_vec(c);
      run_cycle(c);
      cmp_cycle(tag, idx);
   endtask

   // ---------------- test sequence ----------------
   vec_t       hv;
   vec_t       rv;
   logic       rhit;

   initial begin
      res = 1'b1; sync_n = 1'b1; cm_rom_n = 1'b1; cpu_d = 4'h0; io_i = 4'h0;
      prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
      step(); step(); step();
      res = 1'b0;
      chk_idle("reset", 1'b1, 4'h0);

      for (int i = 0; i < 256; i++) begin
         case ($urandom_range(0, 5))
            0:       prog(8'(i), 8'hE2);
            1:       prog(8'(i), 8'hEA);
            default: prog(8'(i), 8'($urandom));
         endcase
      end
      prog(8'h35, 8'hA7);
      prog(8'h80, 8'hE2);
      prog(8'h81, 8'hEA);
      prog(8'hFF, 8'h5C);
      chk_idle("idle_hold", 1'b1, 4'h0);
      chk_idle("sync_from_idle", 1'b0, 4'h0);

      //             a     a3   cma3  m1    m2   cmm2  cmx2  x2   ioin ab  m1oe m1   m2oe m2   x2oe x2   io0  io7
      tbl[0]  = '{8'h35,4'h0,1'b0,4'h0,4'h0,1'b1,1'b1,4'h0,4'h0,7,1'b1,4'hA,1'b1,4'h7,1'b0,4'h0,4'h0,4'h0}; // hit
      tbl[1]  = '{8'h35,4'h1,1'b0,4'h4,4'h1,1'b1,1'b1,4'h0,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h0,4'h0}; // miss
      tbl[2]  = '{8'hFF,4'h0,1'b0,4'h0,4'h0,1'b1,1'b1,4'h0,4'h0,7,1'b1,4'h5,1'b1,4'hC,1'b0,4'h0,4'h0,4'h0}; // top address
      tbl[3]  = '{8'h35,4'h0,1'b1,4'h0,4'h0,1'b1,1'b1,4'h0,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h0,4'h0}; // CM high at A3
      tbl[4]  = '{8'h35,4'h1,1'b0,4'h2,4'h1,1'b1,1'b0,4'h0,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h0,4'h0}; // SRC chip 0
      tbl[5]  = '{8'h80,4'h0,1'b0,4'h0,4'h0,1'b0,1'b1,4'h9,4'h0,7,1'b1,4'hE,1'b1,4'h2,1'b0,4'h0,4'h0,4'h9}; // WRR 9
      tbl[6]  = '{8'h81,4'h0,1'b0,4'h0,4'h0,1'b0,1'b1,4'h0,4'h6,7,1'b1,4'hE,1'b1,4'hA,1'b1,4'h6,4'h9,4'h9}; // RDR 6
      tbl[7]  = '{8'h80,4'h0,1'b0,4'h0,4'h0,1'b1,1'b1,4'h3,4'h0,7,1'b1,4'hE,1'b1,4'h2,1'b0,4'h0,4'h9,4'h9}; // WRR, CM high
      tbl[8]  = '{8'h35,4'h1,1'b0,4'h2,4'h1,1'b1,1'b0,4'h5,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h9,4'h9}; // SRC chip 5
      tbl[9]  = '{8'h35,4'h1,1'b0,4'hE,4'h2,1'b0,1'b1,4'h4,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h9,4'h9}; // WRR deselected
      tbl[10] = '{8'h35,4'h1,1'b0,4'h2,4'h1,1'b1,1'b0,4'h0,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h9,4'h9}; // SRC chip 0
      tbl[11] = '{8'h35,4'h1,1'b0,4'hE,4'h2,1'b0,1'b0,4'h7,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h9,4'h7}; // WRR+SRC same X2
      tbl[12] = '{8'h35,4'h1,1'b0,4'hE,4'h2,1'b0,1'b1,4'h1,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h7,4'h7}; // now deselected
      tbl[13] = '{8'h35,4'h0,1'b0,4'h0,4'h0,1'b1,1'b1,4'h0,4'h0,3,1'b1,4'hA,1'b0,4'h0,1'b0,4'h0,4'h7,4'h7}; // resync in M1
      tbl[14] = '{8'h35,4'h0,1'b0,4'h0,4'h0,1'b1,1'b1,4'h0,4'h0,7,1'b1,4'hA,1'b1,4'h7,1'b0,4'h0,4'h7,4'h7}; // fetch resumes
      tbl[15] = '{8'h35,4'h1,1'b0,4'h2,4'h1,1'b1,1'b0,4'h0,4'h0,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h7,4'h7}; // SRC chip 0
      tbl[16] = '{8'h80,4'h0,1'b0,4'h0,4'h0,1'b0,1'b1,4'h3,4'h0,6,1'b1,4'hE,1'b1,4'h2,1'b0,4'h0,4'h7,4'h7}; // WRR aborted in X2
      tbl[17] = '{8'h80,4'h0,1'b0,4'h0,4'h0,1'b0,1'b1,4'h9,4'h0,7,1'b1,4'hE,1'b1,4'h2,1'b0,4'h0,4'h7,4'h9}; // WRR 9
      tbl[18] = '{8'h81,4'h0,1'b0,4'h0,4'h0,1'b0,1'b1,4'h0,4'h6,5,1'b1,4'hE,1'b1,4'hA,1'b0,4'h0,4'h9,4'h9}; // RDR aborted in X1
      tbl[19] = '{8'h35,4'h1,1'b0,4'h0,4'h0,1'b1,1'b1,4'h0,4'h3,7,1'b0,4'h0,1'b0,4'h0,1'b0,4'h0,4'h9,4'h9}; // no stray X2 drive

      for (int i = 0; i < 20; i++) apply_vec(tbl[i], "tbl", i);

      // ROM write on the same edge as the A3 fetch: old byte out, new byte next time
      hv = '{8'h35,4'h0,1'b0,4'h0,4'h0,1'b1,1'b1,4'h0,4'h0,7,1'b1,4'hA,1'b1,4'h7,1'b0,4'h0,4'h9,4'h9};
      pw_k = 2; pw_addr = 8'h35; pw_data = 8'h11;
      apply_vec(hv, "rbw_old", 0);
      pw_k = -1;
      hv.e_m1 = 4'h1; hv.e_m2 = 4'h1;
      apply_vec(hv, "rbw_new", 0);

      // Reset during M1 while IO_O=9, then wake up on SYNC_N with ROM intact
      res_k = 3;
      apply_vec(hv, "res_m1", 0);
      res_k = -1;
      chk_idle("after_res_0", 1'b1, 4'h0);
      chk_idle("after_res_1", 1'b1, 4'h0);
      chk_idle("after_res_2", 1'b1, 4'h0);
      chk_idle("after_res_sync", 1'b0, 4'h0);
      hv.e_io0 = 4'h0; hv.e_io7 = 4'h0;
      apply_vec(hv, "res_rom_kept", 0);

      // Randomized cycles against the cycle-level model
      io_sel_m = 1'b0;
      io_o_m   = 4'h0;
      for (int n = 0; n < 180; n++) begin
         rv.a     = 8'($urandom);
         rv.a3    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : CHIP;
         rv.cm_a3 = ($urandom_range(0, 4) == 0);
         rhit     = (rv.a3 == CHIP) && !rv.cm_a3;
         rv.m1    = rhit ? 4'h0 : (($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom));
         case ($urandom_range(0, 2))
            0:       rv.m2 = 4'h2;
            1:       rv.m2 = 4'hA;
            default: rv.m2 = 4'($urandom);
         endcase
         if (rhit) rv.m2 = 4'h0;
         rv.cm_m2   = ($urandom_range(0, 3) == 0);
         rv.cm_x2   = ($urandom_range(0, 2) != 0);
         rv.x2      = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
         rv.io_in   = 4'($urandom);
         rv.abort_k = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 5)) : 7;
         pw_k       = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
         pw_addr    = ($urandom_range(0, 1) == 1) ? rv.a : 8'($urandom);
         pw_data    = 8'($urandom);
         model_cycle(rv);
         run_cycle(rv);
         cmp_cycle("rand", n);
      end
      pw_k = -1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
